// File: rtl/ddr5_bank_scheduler_if.sv
// Request and command bus of the DDR5 bank scheduler.
// The master side is the request queue that also consumes the command
// stream; the slave side is the scheduler itself.
interface ddr5_bank_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic [2:0]  req_bg;
  logic [1:0]  req_bank;

  logic [3:0]  cmd;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        done;
  logic [1:0]  done_op;

  modport master (
    output req_valid, req_op, req_row, req_col, req_bg, req_bank,
    input  req_ready, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, done, done_op
  );

  modport slave (
    input  req_valid, req_op, req_row, req_col, req_bg, req_bank,
    output req_ready, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, done, done_op
  );
endinterface

// File: rtl/ddr5_bank_scheduler.sv
// In-order DDR5 command sequencer. Takes one request at a time and walks it
// through PRE / ACT0-ACT1 / RD0-RD1 or WR0-WR1 under an open-page policy,
// tracking open rows and timing counters for all 32 banks (8 BG x 4 banks).
// A command whose counter was loaded with T in cycle c may issue in c+T.
module ddr5_bank_scheduler #(
  parameter int unsigned T_RCD   = 39,
  parameter int unsigned T_RP    = 39,
  parameter int unsigned T_RAS   = 77,
  parameter int unsigned T_RTP   = 18,
  parameter int unsigned T_CWD   = 38,
  parameter int unsigned T_BURST = 8,
  parameter int unsigned T_WR    = 72,
  parameter int unsigned T_CCD_L = 12,
  parameter int unsigned T_CCD_S = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  ddr5_bank_scheduler_if.slave bus
);

  localparam logic [7:0] RCD    = 8'(T_RCD);
  localparam logic [7:0] RP     = 8'(T_RP);
  localparam logic [7:0] RAS    = 8'(T_RAS);
  localparam logic [7:0] RTP    = 8'(T_RTP);
  localparam logic [7:0] WR_REC = 8'(T_CWD + T_BURST + T_WR);
  localparam logic [7:0] CCD_L  = 8'(T_CCD_L);
  localparam logic [7:0] CCD_S  = 8'(T_CCD_S);

  typedef enum logic [3:0] {
    S_IDLE, S_DECIDE, S_PRE_WAIT, S_PRE, S_ACT_WAIT,
    S_ACT0, S_ACT1, S_COL_WAIT, S_COL0, S_COL1
  } state_e;

  typedef enum logic [3:0] {
    CMD_NULL = 4'd0, CMD_ACT0 = 4'd1, CMD_ACT1 = 4'd2, CMD_RD0 = 4'd3,
    CMD_RD1  = 4'd4, CMD_WR0  = 4'd5, CMD_WR1  = 4'd6, CMD_PRE = 4'd7
  } cmd_e;

  state_e      state;

  // Captured request.
  logic [1:0]  op_q;
  logic [15:0] row_q;
  logic [9:0]  col_q;
  logic [2:0]  bg_q;
  logic [1:0]  bank_q;
  logic [4:0]  bidx;

  // Bank table, exposed by name for a future refresh block.
  logic        bank_open [32];
  logic [15:0] open_row  [32];
  logic [7:0]  act_cnt   [32];
  logic [7:0]  pre_cnt   [32];
  logic [7:0]  col_cnt   [32];

  // Inter-column spacing.
  logic [7:0]  ccd_l_cnt;
  logic [7:0]  ccd_s_cnt;
  logic [2:0]  last_bg;

  // Registered outputs.
  logic        req_ready_q;
  cmd_e        cmd_q;
  logic [2:0]  cmd_bg_q;
  logic [1:0]  cmd_bank_q;
  logic [15:0] cmd_row_q;
  logic [9:0]  cmd_col_q;
  logic        done_q;
  logic [1:0]  done_op_q;

  // Gates and issue strobes.
  logic        is_write;
  logic        row_match;
  logic        pre_ok;
  logic        act_ok;
  logic        col_ok;
  logic        enter_pre;
  logic        enter_act;
  logic        enter_col;
  logic [7:0]  pre_dec;
  logic [7:0]  col_rec;

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  // The gate is judged one cycle ahead of the command it releases, so a
  // counter reading 1 now will read 0 in the cycle the command issues.
  function automatic logic expires(input logic [7:0] v);
    return v <= 8'd1;
  endfunction

  assign bidx = {bg_q, bank_q};

  // Timing gates for the target bank and the strobes that issue commands.
  always_comb begin
    is_write  = (op_q == 2'd1);
    row_match = bank_open[bidx] && (open_row[bidx] == row_q);
    pre_ok    = expires(pre_cnt[bidx]);
    act_ok    = expires(act_cnt[bidx]);
    col_ok    = expires(col_cnt[bidx]) &&
                ((bg_q == last_bg) ? expires(ccd_l_cnt) : expires(ccd_s_cnt));
    enter_pre = pre_ok &&
                ((state == S_DECIDE && bank_open[bidx] && !row_match) ||
                 state == S_PRE_WAIT);
    enter_act = act_ok &&
                ((state == S_DECIDE && !bank_open[bidx]) ||
                 state == S_PRE || state == S_ACT_WAIT);
    enter_col = col_ok &&
                ((state == S_DECIDE && row_match) ||
                 state == S_ACT1 || state == S_COL_WAIT);
    pre_dec   = sat_dec(pre_cnt[bidx]);
    col_rec   = is_write ? WR_REC : RTP;
  end

  // Bank table: all counters count down each cycle; issue strobes reload them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the whole table is reset on purpose: a bank must never look open,
      // or carry a stale timer, after reset.
      for (int i = 0; i < 32; i++) begin
        bank_open[i] <= 1'b0;
        open_row[i]  <= '0;
        act_cnt[i]   <= '0;
        pre_cnt[i]   <= '0;
        col_cnt[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout, so the per-bank loads below override
      // the decrement cleanly and every reader sees last cycle's value.
      for (int i = 0; i < 32; i++) begin
        act_cnt[i] <= sat_dec(act_cnt[i]);
        pre_cnt[i] <= sat_dec(pre_cnt[i]);
        col_cnt[i] <= sat_dec(col_cnt[i]);
      end
      if (enter_pre) begin
        bank_open[bidx] <= 1'b0;
        act_cnt[bidx]   <= RP;
      end
      if (enter_act) begin
        bank_open[bidx] <= 1'b1;
        open_row[bidx]  <= row_q;
        col_cnt[bidx]   <= RCD;
        pre_cnt[bidx]   <= RAS;
      end
      if (enter_col) begin
        pre_cnt[bidx] <= (pre_dec > col_rec) ? pre_dec : col_rec;
      end
    end
  end

  // Request FSM with registered command outputs and CCD tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      req_ready_q <= 1'b1;
      op_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      bg_q        <= '0;
      bank_q      <= '0;
      ccd_l_cnt   <= '0;
      ccd_s_cnt   <= '0;
      last_bg     <= '0;
      cmd_q       <= CMD_NULL;
      cmd_bg_q    <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      done_q      <= 1'b0;
      done_op_q   <= '0;
    end else begin
      cmd_q       <= CMD_NULL;
      cmd_bg_q    <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      done_q      <= 1'b0;
      done_op_q   <= '0;
      req_ready_q <= 1'b0;
      ccd_l_cnt   <= sat_dec(ccd_l_cnt);
      ccd_s_cnt   <= sat_dec(ccd_s_cnt);

      if (enter_pre) begin
        state      <= S_PRE;
        cmd_q      <= CMD_PRE;
        cmd_bg_q   <= bg_q;
        cmd_bank_q <= bank_q;
      end else if (enter_act) begin
        state      <= S_ACT0;
        cmd_q      <= CMD_ACT0;
        cmd_bg_q   <= bg_q;
        cmd_bank_q <= bank_q;
        cmd_row_q  <= row_q;
      end else if (enter_col) begin
        state      <= S_COL0;
        if (is_write) cmd_q <= CMD_WR0;
        else          cmd_q <= CMD_RD0;
        cmd_bg_q   <= bg_q;
        cmd_bank_q <= bank_q;
        cmd_col_q  <= col_q;
        ccd_l_cnt  <= CCD_L;
        ccd_s_cnt  <= CCD_S;
        last_bg    <= bg_q;
      end else begin
        case (state)
          S_IDLE: begin
            req_ready_q <= 1'b1;
            if (bus.req_valid) begin
              op_q        <= bus.req_op;
              row_q       <= bus.req_row;
              col_q       <= bus.req_col;
              bg_q        <= bus.req_bg;
              bank_q      <= bus.req_bank;
              req_ready_q <= 1'b0;
              state       <= S_DECIDE;
            end
          end
          S_DECIDE: begin
            if (row_match)             state <= S_COL_WAIT;
            else if (!bank_open[bidx]) state <= S_ACT_WAIT;
            else                       state <= S_PRE_WAIT;
          end
          S_PRE:  state <= S_ACT_WAIT;
          S_ACT0: begin
            state      <= S_ACT1;
            cmd_q      <= CMD_ACT1;
            cmd_bg_q   <= bg_q;
            cmd_bank_q <= bank_q;
            cmd_row_q  <= row_q;
          end
          S_ACT1: state <= S_COL_WAIT;
          S_COL0: begin
            state      <= S_COL1;
            if (is_write) cmd_q <= CMD_WR1;
            else          cmd_q <= CMD_RD1;
            cmd_bg_q   <= bg_q;
            cmd_bank_q <= bank_q;
            cmd_col_q  <= col_q;
            done_q     <= 1'b1;
            done_op_q  <= op_q;
          end
          S_COL1: begin
            state       <= S_IDLE;
            req_ready_q <= 1'b1;
          end
          default: state <= state;
        endcase
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_bg    = cmd_bg_q;
  assign bus.cmd_bank  = cmd_bank_q;
  assign bus.cmd_row   = cmd_row_q;
  assign bus.cmd_col   = cmd_col_q;
  assign bus.done      = done_q;
  assign bus.done_op   = done_op_q;

endmodule
